decode_execute_unit: RTL and testbench

- Decode/execute slice of the basic pipelined CPU.
- Combinationally decodes the 32-bit instruction in the issue register into its type and register/immediate fields.
- On each clock, captures the instruction (or a NO-OP bubble when stalled) and its two register-file operands into decode-stage registers.
- Computes the ALU operation on those registered operands and registers the result, for use by the memory/write-back stages.

---
 rtl/decode_execute_unit.sv | 96 +++++++++
 tb/tb_decode_execute_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_unit.sv
// decode_execute_unit: field decode, decode-stage operand capture and registered 32-bit ALU
module decode_execute_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic [31:0] reg_value_0,
    input  logic [31:0] reg_value_1,
    output logic [4:0]  instruction_type,
    output logic [4:0]  load_imm_reg,
    output logic [4:0]  load_mem_reg,
    output logic [4:0]  store_data_reg,
    output logic [4:0]  alu_op_reg_0,
    output logic [4:0]  jump_condition_reg,
    output logic [4:0]  load_mem_addr_reg,
    output logic [4:0]  store_addr_reg,
    output logic [4:0]  alu_op_reg_1,
    output logic [4:0]  jump_address_reg,
    output logic [4:0]  alu_op_reg_res,
    output logic [4:0]  alu_operation,
    output logic [31:0] load_imm_data,
    output logic [31:0] ex_instruction,
    output logic [31:0] alu_result,
    output logic [4:0]  ex_result_reg
);
    localparam logic [4:0] ALU_OP = 5'd5;
    logic [31:0] ex_instruction_q, ex_instruction_d;
    logic [31:0] op0_q, op1_q;
    logic [31:0] alu_result_q, alu_result_d;
    logic [4:0]  ex_result_reg_q;
    logic [31:0] alu_out;
    logic [4:0]  op_select;
    logic [4:0]  shamt;

    assign instruction_type   = instruction[31:27];
    assign load_imm_reg       = instruction[26:22];
    assign load_mem_reg       = instruction[26:22];
    assign store_data_reg     = instruction[26:22];
    assign alu_op_reg_0       = instruction[26:22];
    assign jump_condition_reg = instruction[26:22];
    assign load_mem_addr_reg  = instruction[21:17];
    assign store_addr_reg     = instruction[21:17];
    assign alu_op_reg_1       = instruction[21:17];
    assign jump_address_reg   = instruction[21:17];
    assign alu_op_reg_res     = instruction[16:12];
    assign alu_operation      = instruction[11:7];
    assign load_imm_data      = {16'h0, instruction[15:0]};

    assign op_select = ex_instruction_q[11:7];
    assign shamt     = op1_q[4:0];

    always_comb begin
        alu_out = 32'h0;
        case (op_select)
            5'd0:  alu_out = op0_q + op1_q;
            5'd1:  alu_out = op0_q - op1_q;
            5'd2:  alu_out = op0_q & op1_q;
            5'd3:  alu_out = op0_q | op1_q;
            5'd4:  alu_out = op0_q ^ op1_q;
            5'd5:  alu_out = op0_q << shamt;
            5'd6:  alu_out = op0_q >> shamt;
            5'd7:  alu_out = $unsigned($signed(op0_q) >>> shamt);
            5'd8:  alu_out = {31'h0, $signed(op0_q) < $signed(op1_q)};
            5'd9:  alu_out = {31'h0, op0_q < op1_q};
            5'd10: alu_out = {31'h0, op0_q == op1_q};
            5'd11: alu_out = ~op0_q;
            5'd12: alu_out = op0_q;
            default: alu_out = 32'h0;
        endcase
    end

    always_comb begin
        ex_instruction_d = stall ? 32'h0 : instruction;
        alu_result_d     = (ex_instruction_q[31:27] == ALU_OP) ? alu_out : 32'h0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_instruction_q <= 32'h0;
            op0_q            <= 32'h0;
            op1_q            <= 32'h0;
            alu_result_q     <= 32'h0;
            ex_result_reg_q  <= 5'h0;
        end else begin
            ex_instruction_q <= ex_instruction_d;
            op0_q            <= reg_value_0;
            op1_q            <= reg_value_1;
            alu_result_q     <= alu_result_d;
            ex_result_reg_q  <= ex_instruction_q[16:12];
        end
    end

    assign ex_instruction = ex_instruction_q;
    assign alu_result     = alu_result_q;
    assign ex_result_reg  = ex_result_reg_q;
endmodule

// File: tb/tb_decode_execute_unit.sv
// tb_decode_execute_unit: directed and random checks against a behavioural pipeline model
module tb_decode_execute_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic        stall = 1'b0;
    logic [31:0] reg_value_0 = 32'h0;
    logic [31:0] reg_value_1 = 32'h0;
    logic [4:0]  instruction_type, load_imm_reg, load_mem_reg, store_data_reg, alu_op_reg_0;
    logic [4:0]  jump_condition_reg, load_mem_addr_reg, store_addr_reg, alu_op_reg_1;
    logic [4:0]  jump_address_reg, alu_op_reg_res, alu_operation, ex_result_reg;
    logic [31:0] load_imm_data, ex_instruction, alu_result;
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] pend_res = 32'h0;
    logic [4:0]  pend_dst = 5'h0;

    decode_execute_unit dut (
        .clk(clk), .rst(rst), .instruction(instruction), .stall(stall),
        .reg_value_0(reg_value_0), .reg_value_1(reg_value_1),
        .instruction_type(instruction_type), .load_imm_reg(load_imm_reg),
        .load_mem_reg(load_mem_reg), .store_data_reg(store_data_reg),
        .alu_op_reg_0(alu_op_reg_0), .jump_condition_reg(jump_condition_reg),
        .load_mem_addr_reg(load_mem_addr_reg), .store_addr_reg(store_addr_reg),
        .alu_op_reg_1(alu_op_reg_1), .jump_address_reg(jump_address_reg),
        .alu_op_reg_res(alu_op_reg_res), .alu_operation(alu_operation),
        .load_imm_data(load_imm_data), .ex_instruction(ex_instruction),
        .alu_result(alu_result), .ex_result_reg(ex_result_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int t, input int r0, input int r1, input int rd, input int op);
        logic [31:0] w;
        w = 32'h0;
        w[31:27] = t[4:0];
        w[26:22] = r0[4:0];
        w[21:17] = r1[4:0];
        w[16:12] = rd[4:0];
        w[11:7]  = op[4:0];
        return w;
    endfunction

    // Reference ALU: arithmetic in 64 bits, shifts as repeated single-bit moves
    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint ua, ub;
        logic [31:0] r;
        int sh;
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sa = a[31] ? ua - 64'sd4294967296 : ua;
        sb = b[31] ? ub - 64'sd4294967296 : ub;
        sh = int'(b % 32);
        r = a;
        case (op)
            0: r = 32'((ua + ub) % 64'sd4294967296);
            1: r = 32'((ua - ub + 64'sd4294967296) % 64'sd4294967296);
            2: for (int i = 0; i < 32; i++) r[i] = a[i] && b[i];
            3: for (int i = 0; i < 32; i++) r[i] = a[i] || b[i];
            4: for (int i = 0; i < 32; i++) r[i] = a[i] != b[i];
            5: for (int i = 0; i < sh; i++) r = {r[30:0], 1'b0};
            6: for (int i = 0; i < sh; i++) r = {1'b0, r[31:1]};
            7: for (int i = 0; i < sh; i++) r = {a[31], r[31:1]};
            8: r = (sa < sb) ? 32'd1 : 32'd0;
            9: r = (ua < ub) ? 32'd1 : 32'd0;
            10: r = (ua == ub) ? 32'd1 : 32'd0;
            11: r = 32'(64'sd4294967295 - ua);
            12: r = a;
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // One pipeline cycle: drive, clock, compare against model, advance model
    task automatic step(input logic [31:0] ins, input logic st, input logic [31:0] a, input logic [31:0] b);
        instruction = ins;
        stall = st;
        reg_value_0 = a;
        reg_value_1 = b;
        @(posedge clk);
        #1;
        chk("ex_instruction", ex_instruction, st ? 32'h0 : ins);
        chk("alu_result", alu_result, pend_res);
        chk("ex_result_reg", {27'h0, ex_result_reg}, {27'h0, pend_dst});
        pend_res = (st || ins[31:27] != 5'd5) ? 32'h0 : ref_alu(int'(ins[11:7]), a, b);
        pend_dst = st ? 5'h0 : ins[16:12];
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] ops [0:5];
        ops[0] = 32'h0; ops[1] = 32'hFFFFFFFF; ops[2] = 32'h80000000;
        ops[3] = 32'h7FFFFFFF; ops[4] = 32'd1; ops[5] = 32'd33;
        #2;
        instruction = {5'd5, 5'd3, 5'd4, 5'd7, 5'd1, 7'd0};
        #1;
        chk("rst_ex_instruction", ex_instruction, 32'h0);
        chk("rst_alu_result", alu_result, 32'h0);
        chk("rst_ex_result_reg", {27'h0, ex_result_reg}, 32'h0);
        chk("dec_type", {27'h0, instruction_type}, 32'd5);
        chk("dec_r0", {27'h0, alu_op_reg_0}, 32'd3);
        chk("dec_r1", {27'h0, alu_op_reg_1}, 32'd4);
        chk("dec_rd", {27'h0, alu_op_reg_res}, 32'd7);
        chk("dec_op", {27'h0, alu_operation}, 32'd1);
        chk("dec_mirror", {store_data_reg, jump_address_reg, load_mem_reg, store_addr_reg}, {12'h0, 5'd3, 5'd4, 5'd3, 5'd4});
        instruction = {5'd2, 5'd9, 6'd0, 16'hBEEF};
        #1;
        chk("dec_load_imm_data", load_imm_data, 32'h0000BEEF);
        chk("dec_load_imm_reg", {27'h0, load_imm_reg}, 32'd9);
        @(posedge clk);
        #1;
        chk("rst_held", ex_instruction, 32'h0);
        #2 rst = 1'b1;

        step(mk(5, 1, 2, 7, 0), 1'b0, 32'd10, 32'd32);
        step(mk(5, 1, 2, 8, 1), 1'b0, 32'd5, 32'd7);
        chk("add_42", alu_result, 32'd42);
        step(mk(5, 0, 0, 9, 8), 1'b0, 32'hFFFFFFFF, 32'd1);
        chk("sub_wrap", alu_result, 32'hFFFFFFFE);
        step(mk(5, 0, 0, 9, 9), 1'b0, 32'hFFFFFFFF, 32'd1);
        chk("slt", alu_result, 32'd1);
        step(mk(5, 0, 0, 9, 7), 1'b0, 32'h80000000, 32'd4);
        chk("sltu", alu_result, 32'd0);
        step(mk(5, 0, 0, 9, 6), 1'b0, 32'h80000000, 32'd4);
        chk("sra", alu_result, 32'hF8000000);
        step(mk(5, 0, 0, 9, 0), 1'b0, 32'hFFFFFFFF, 32'd1);
        chk("srl", alu_result, 32'h08000000);
        step(mk(5, 0, 0, 9, 5), 1'b0, 32'd3, 32'd33);
        chk("add_wrap", alu_result, 32'h0);
        step(mk(5, 1, 2, 3, 0), 1'b0, 32'd1, 32'd2);
        chk("sll_33", alu_result, 32'd6);
        step(mk(5, 1, 2, 4, 0), 1'b1, 32'd4, 32'd5);
        chk("stall_ex_instruction", ex_instruction, 32'h0);
        step(mk(4, 1, 2, 6, 0), 1'b0, 32'd3, 32'd4);
        chk("stall_alu_result", alu_result, 32'h0);
        chk("stall_ex_result_reg", {27'h0, ex_result_reg}, 32'h0);
        step(mk(0, 0, 0, 0, 0), 1'b0, 32'd0, 32'd0);
        step(mk(0, 0, 0, 0, 0), 1'b0, 32'd0, 32'd0);
        chk("store_alu_result", alu_result, 32'h0);

        for (int i = 0; i < 300; i++) begin
            int t;
            t = ($urandom_range(0, 3) != 0) ? 5 : int'($urandom_range(0, 31));
            w = mk(t, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                   ($urandom_range(0, 7) != 0) ? $urandom_range(0, 12) : $urandom_range(13, 31));
            w[6:0] = 7'($urandom);
            step(w, $urandom_range(0, 4) == 0,
                 ($urandom_range(0, 2) == 0) ? ops[$urandom_range(0, 5)] : $urandom,
                 ($urandom_range(0, 2) == 0) ? ops[$urandom_range(0, 5)] : $urandom);
        end

        step(mk(5, 1, 2, 11, 0), 1'b0, 32'd20, 32'd22);
        step(mk(5, 1, 2, 12, 12), 1'b0, 32'd99, 32'd0);
        #2 rst = 1'b0;
        #1;
        chk("async_ex_instruction", ex_instruction, 32'h0);
        chk("async_alu_result", alu_result, 32'h0);
        chk("async_ex_result_reg", {27'h0, ex_result_reg}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_alu_result", alu_result, 32'h0);
        #2 rst = 1'b1;
        pend_res = 32'h0;
        pend_dst = 5'h0;
        step(mk(5, 1, 2, 13, 0), 1'b0, 32'd1, 32'd1);
        step(mk(0, 0, 0, 0, 0), 1'b0, 32'd0, 32'd0);
        chk("post_rst_add", alu_result, 32'd2);
        chk("post_rst_dst", {27'h0, ex_result_reg}, 32'd13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
